// File: rtl/color_pkg.sv
// Shared types and constants for the colour fader.
// Colour words are {R,G,B}, 8 bits per channel.
package color_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb24_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FADE = 1'b1
   } fader_state_t;

   localparam logic [23:0] COLOR_BLACK = 24'h000000;

endpackage

// File: rtl/channel_stepper.sv
// One 8-bit colour channel that steps toward its target.
// Moves by at most STEP per enabled cycle, never past the target.
module channel_stepper #(
   parameter int STEP = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tgt,
   input  logic       step_en,
   output logic [7:0] cur,
   output logic       at_target
);

   localparam logic [8:0] STEP9 = 9'(STEP);

   logic [8:0] diff;
   logic [8:0] delta;
   logic [7:0] nxt;

   // Clamped step toward the target in 9-bit unsigned arithmetic
   always_comb begin
      diff  = 9'd0;
      delta = 9'd0;
      nxt   = cur;
      if (cur < tgt) begin
         diff  = {1'b0, tgt} - {1'b0, cur};
         delta = (diff < STEP9) ? diff : STEP9;
         nxt   = cur + delta[7:0];
      end else if (cur > tgt) begin
         diff  = {1'b0, cur} - {1'b0, tgt};
         delta = (diff < STEP9) ? diff : STEP9;
         nxt   = cur - delta[7:0];
      end
   end

   // Post-update comparison, used by the top to detect completion
   assign at_target = (nxt == tgt);

   // Channel value register, updated only on fade ticks
   always_ff @(posedge clk) begin
      if (reset) begin
         cur <= 8'd0;
      end else if (step_en) begin
         cur <= nxt;
      end
   end

endmodule

// File: rtl/color_fader.sv
// Fades the output colour toward a handshaken target colour.
// One step per prescaler tick, done pulse on arrival.
module color_fader
   import color_pkg::*;
#(
   parameter int CLK_DIV = 100000,
   parameter int STEP    = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] target_hex,
   input  logic        target_valid,
   output logic        target_ready,
   output logic [23:0] color_hex,
   output logic        busy,
   output logic        done
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

   fader_state_t state;
   fader_state_t state_nxt;
   rgb24_t       tgt_q;
   rgb24_t       cur;
   logic [CW-1:0] cnt;
   logic         accept;
   logic         same;
   logic         tick;
   logic         all_at;
   logic         at_r;
   logic         at_g;
   logic         at_b;
   logic         done_q;

   assign accept = target_valid && (state == IDLE);
   assign same   = (target_hex == color_hex);
   assign tick   = (state == FADE) && (cnt == CNT_MAX);
   assign all_at = at_r && at_g && at_b;

   assign target_ready = (state == IDLE);
   assign busy         = (state == FADE);
   assign done         = done_q;
   assign color_hex    = cur;

   channel_stepper #(.STEP(STEP)) u_r (
      .clk       (clk),
      .reset     (reset),
      .tgt       (tgt_q.r),
      .step_en   (tick),
      .cur       (cur.r),
      .at_target (at_r)
   );

   channel_stepper #(.STEP(STEP)) u_g (
      .clk       (clk),
      .reset     (reset),
      .tgt       (tgt_q.g),
      .step_en   (tick),
      .cur       (cur.g),
      .at_target (at_g)
   );

   channel_stepper #(.STEP(STEP)) u_b (
      .clk       (clk),
      .reset     (reset),
      .tgt       (tgt_q.b),
      .step_en   (tick),
      .cur       (cur.b),
      .at_target (at_b)
   );

   // Next-state decode for the idle/fade controller
   always_comb begin
      state_nxt = state;
      unique case (1'b1)
         (state == IDLE): begin
            if (accept && !same) state_nxt = FADE;
         end
         (state == FADE): begin
            if (tick && all_at) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, target latch and done pulse registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         tgt_q  <= rgb24_t'(COLOR_BLACK);
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= (accept && same) || (tick && all_at);
         if (accept) tgt_q <= rgb24_t'(target_hex);
      end
   end

   // Prescaler runs only while fading and restarts on each accept
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= '0;
      end else if (state == FADE) begin
         cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      end
   end

endmodule
